// File: rtl/id_branch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_branch_unit_pkg
// Purpose : Shared opcode, NOP-word and instruction-field constants for the
//           decode-side branch unit.
// Revision: 1.0 - initial release
// ============================================================================
package id_branch_unit_pkg;

    localparam logic [5:0]  OP_BEZ   = 6'd40;
    localparam logic [5:0]  OP_BNE   = 6'd41;
    localparam logic [5:0]  OP_JMP   = 6'd42;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

endpackage
`default_nettype wire

// File: rtl/id_branch_unit_branch_cond.sv
`default_nettype none
// ============================================================================
// Module  : branch_cond
// Purpose : Combinational branch decode and condition evaluation from the
//           opcode and the two register operands.
// Revision: 1.0 - initial release
// ============================================================================
module branch_cond
    import id_branch_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] Val1,
    input  logic [WIDTH-1:0] Val2,
    output logic             is_branch,
    output logic             cond_true
);

    always_comb begin
        is_branch = 1'b0;
        cond_true = 1'b0;
        case (opcode)
            OP_BEZ: begin
                is_branch = 1'b1;
                cond_true = (Val1 == '0);
            end
            OP_BNE: begin
                is_branch = 1'b1;
                cond_true = (Val1 != Val2);
            end
            OP_JMP: begin
                is_branch = 1'b1;
                cond_true = 1'b1;
            end
            default: begin
                is_branch = 1'b0;
                cond_true = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/id_branch_unit.sv
`default_nettype none
// ============================================================================
// Module  : id_branch_unit
// Purpose : IF/ID pipeline register with branch resolution, wrong-path
//           squash and hazard freeze. Optional counters: BRANCH_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module id_branch_unit
    import id_branch_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC,
    input  logic [31:0]      Instruction,
    input  logic             freeze,
    input  logic [WIDTH-1:0] Val1,
    input  logic [WIDTH-1:0] Val2,
    output logic             Br_taken,
    output logic [WIDTH-1:0] Br_Addr,
    output logic [WIDTH-1:0] ID_PC,
    output logic [31:0]      ID_Instruction,
    output logic             ID_valid
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      br_count,
    output logic [31:0]      taken_count
`endif
);

    logic [WIDTH-1:0] r_id_pc;
    logic [31:0]      r_id_instr;
    logic             r_id_valid;

    logic             w_is_branch;
    logic             w_cond_true;
    logic             w_br_eval;
    logic             w_br_taken;
    logic [WIDTH-1:0] w_imm_sext;
    logic [WIDTH-1:0] w_target;

    branch_cond #(
        .WIDTH (WIDTH)
    ) u_branch_cond (
        .opcode    (r_id_instr[OPCODE_MSB:OPCODE_LSB]),
        .Val1      (Val1),
        .Val2      (Val2),
        .is_branch (w_is_branch),
        .cond_true (w_cond_true)
    );

    // A bubble (valid=0) or a frozen slot can never redirect fetch.
    assign w_br_eval  = r_id_valid & ~freeze & w_is_branch;
    assign w_br_taken = w_br_eval & w_cond_true;

    assign w_imm_sext = WIDTH'($signed(r_id_instr[IMM_MSB:IMM_LSB]));
    assign w_target   = r_id_pc + WIDTH'(4) + (w_imm_sext << 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_pc    <= '0;
            r_id_instr <= NOP_WORD;
            r_id_valid <= 1'b0;
        end else if (w_br_taken) begin
            r_id_pc    <= '0;
            r_id_instr <= NOP_WORD;
            r_id_valid <= 1'b0;
        end else if (!freeze) begin
            r_id_pc    <= PC;
            r_id_instr <= Instruction;
            r_id_valid <= 1'b1;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_taken_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            if (w_br_eval) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (w_br_taken) begin
                r_taken_count <= r_taken_count + 32'd1;
            end
        end
    end

    assign br_count    = r_br_count;
    assign taken_count = r_taken_count;
`endif

    assign Br_taken       = w_br_taken;
    assign Br_Addr        = w_is_branch ? w_target : '0;
    assign ID_PC          = r_id_pc;
    assign ID_Instruction = r_id_instr;
    assign ID_valid       = r_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_id_branch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_branch_unit
// Purpose : Self-checking bench for id_branch_unit against a behavioural
//           pipeline-slot model; counters covered when BRANCH_STATS_EN is set.
// Revision: 1.0 - initial release
// ============================================================================
module tb_id_branch_unit;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic [W-1:0]  PC;
    logic [31:0]   Instruction;
    logic          freeze;
    logic [W-1:0]  Val1;
    logic [W-1:0]  Val2;
    logic          Br_taken;
    logic [W-1:0]  Br_Addr;
    logic [W-1:0]  ID_PC;
    logic [31:0]   ID_Instruction;
    logic          ID_valid;
`ifdef BRANCH_STATS_EN
    logic [31:0]   br_count;
    logic [31:0]   taken_count;
`endif

    int checks = 0;
    int errors = 0;

    // Model of the ID slot and of the statistics counters.
    logic [W-1:0]  m_pc;
    logic [31:0]   m_ins;
    bit            m_valid;
    int unsigned   m_br;
    int unsigned   m_tk;

    id_branch_unit #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .Instruction    (Instruction),
        .freeze         (freeze),
        .Val1           (Val1),
        .Val2           (Val2),
        .Br_taken       (Br_taken),
        .Br_Addr        (Br_Addr),
        .ID_PC          (ID_PC),
        .ID_Instruction (ID_Instruction),
        .ID_valid       (ID_valid)
`ifdef BRANCH_STATS_EN
        ,
        .br_count       (br_count),
        .taken_count    (taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_is_br(input logic [31:0] ins);
        int op;
        op = int'(ins[31:26]);
        return (op == 40) || (op == 41) || (op == 42);
    endfunction

    function automatic bit m_taken();
        int op;
        op = int'(m_ins[31:26]);
        if (!m_valid || freeze) return 1'b0;
        if (op == 40) return (Val1 == 0);
        if (op == 41) return (Val1 != Val2);
        if (op == 42) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] m_addr();
        int signed   imm;
        logic [W-1:0] t;
        if (!m_is_br(m_ins)) return '0;
        imm = int'($signed(m_ins[15:0]));
        t = m_pc + W'(4) + W'(imm * 4);
        return t;
    endfunction

    function automatic logic [31:0] mk(input int op, input logic [15:0] imm);
        logic [5:0] o;
        o = op[5:0];
        return {o, 10'h000, imm};
    endfunction

    task automatic model_reset();
        m_pc = '0; m_ins = '0; m_valid = 1'b0; m_br = 0; m_tk = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs now applied.
    task automatic tick();
        bit tk;
        tk = m_taken();
        if (m_valid && !freeze && m_is_br(m_ins)) m_br++;
        if (tk) m_tk++;
        @(posedge clk);
        if (tk) begin
            m_pc = '0; m_ins = '0; m_valid = 1'b0;
        end else if (!freeze) begin
            m_pc = PC; m_ins = Instruction; m_valid = 1'b1;
        end
        #1;
    endtask

    task automatic step(input logic [W-1:0] pc, input logic [31:0] ins,
                        input logic frz, input logic [W-1:0] v1, input logic [W-1:0] v2);
        PC = pc; Instruction = ins; freeze = frz; Val1 = v1; Val2 = v2;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; PC = '0; Instruction = 32'h0; freeze = 1'b0; Val1 = '0; Val2 = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        checks++; if (ID_PC !== 0) begin errors++; $display("FAIL reset_id_pc: got %h expected 0", ID_PC); end
        checks++; if (ID_Instruction !== 0) begin errors++; $display("FAIL reset_id_instr: got %h expected 0", ID_Instruction); end
        checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", ID_valid); end
        checks++; if (Br_taken !== 1'b0) begin errors++; $display("FAIL reset_br_taken: got %b expected 0", Br_taken); end
        checks++; if (Br_Addr !== 0) begin errors++; $display("FAIL reset_br_addr: got %h expected 0", Br_Addr); end
`ifdef BRANCH_STATS_EN
        checks++; if (br_count !== 0 || taken_count !== 0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", br_count, taken_count); end
`endif
        rst = 1'b0;
        tick();
        checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL release_valid: got %b expected 1", ID_valid); end
        checks++; if (Br_taken !== 1'b0) begin errors++; $display("FAIL release_br_taken: got %b expected 0", Br_taken); end
    endtask

    task automatic test_jmp();
        step(W'(32'h10), mk(42, 16'd3), 1'b0, '0, '0);
        checks++; if (Br_taken !== 1'b1) begin errors++; $display("FAIL jmp_taken: got %b expected 1", Br_taken); end
        checks++; if (Br_Addr !== W'(32'h20)) begin errors++; $display("FAIL jmp_addr: got %h expected 20", Br_Addr); end
        step(W'(32'h14), mk(1, 16'h1234), 1'b0, '0, '0);
        checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL jmp_squash_valid: got %b expected 0", ID_valid); end
        checks++; if (ID_Instruction !== 0) begin errors++; $display("FAIL jmp_squash_instr: got %h expected 0", ID_Instruction); end
        checks++; if (Br_taken !== 1'b0) begin errors++; $display("FAIL jmp_bubble_taken: got %b expected 0", Br_taken); end
    endtask

    task automatic test_bne();
        step(W'(32'h40), mk(41, 16'hFFFE), 1'b0, '0, '0);
        Val1 = W'(5); Val2 = W'(5); #1;
        checks++; if (Br_taken !== 1'b0) begin errors++; $display("FAIL bne_equal_taken: got %b expected 0", Br_taken); end
        Val2 = W'(6); #1;
        checks++; if (Br_taken !== 1'b1) begin errors++; $display("FAIL bne_diff_taken: got %b expected 1", Br_taken); end
        checks++; if (Br_Addr !== W'(32'h3C)) begin errors++; $display("FAIL bne_addr: got %h expected 3c", Br_Addr); end
        step(W'(32'h44), mk(3, 16'h0), 1'b0, W'(5), W'(6));
        checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL bne_squash: got %b expected 0", ID_valid); end
    endtask

    task automatic test_freeze();
        logic [31:0] bez;
        bez = mk(40, 16'd1);
        step(W'(32'h80), bez, 1'b0, W'(9), '0);
        PC = W'(32'h84); Instruction = mk(5, 16'h55); freeze = 1'b1; Val1 = '0; #1;
        checks++; if (Br_taken !== 1'b0) begin errors++; $display("FAIL freeze_taken: got %b expected 0", Br_taken); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ID_PC !== W'(32'h80) || ID_Instruction !== bez || ID_valid !== 1'b1)
                begin errors++; $display("FAIL freeze_hold: got %h/%h/%b expected 80/%h/1", ID_PC, ID_Instruction, ID_valid, bez); end
            checks++; if (Br_taken !== 1'b0) begin errors++; $display("FAIL freeze_hold_taken: got %b expected 0", Br_taken); end
        end
        freeze = 1'b0; #1;
        checks++; if (Br_taken !== 1'b1) begin errors++; $display("FAIL unfreeze_taken: got %b expected 1", Br_taken); end
        checks++; if (Br_Addr !== W'(32'h88)) begin errors++; $display("FAIL unfreeze_addr: got %h expected 88", Br_Addr); end
        tick();
        checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL unfreeze_squash: got %b expected 0", ID_valid); end
    endtask

    task automatic test_rst_mid_branch();
        step(W'(32'h200), mk(42, 16'd5), 1'b0, '0, '0);
        checks++; if (Br_taken !== 1'b1) begin errors++; $display("FAIL rstmid_pre_taken: got %b expected 1", Br_taken); end
        rst = 1'b1; #1;
        checks++; if (Br_taken !== 1'b0) begin errors++; $display("FAIL rstmid_taken: got %b expected 0", Br_taken); end
        checks++; if (ID_PC !== 0 || ID_Instruction !== 0 || ID_valid !== 1'b0 || Br_Addr !== 0)
            begin errors++; $display("FAIL rstmid_regs: got %h/%h/%b/%h expected all 0", ID_PC, ID_Instruction, ID_valid, Br_Addr); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        int sel;
        logic [5:0] op;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: op = 6'd40;
                1: op = 6'd41;
                2: op = 6'd42;
                3: op = 6'd43;
                4: op = 6'd39;
                default: op = 6'($urandom_range(0, 63));
            endcase
            PC = W'($urandom) & ~W'(3);
            Instruction = ($urandom_range(0, 7) == 0) ? 32'h0 : {op, 10'($urandom), 16'($urandom)};
            freeze = ($urandom_range(0, 3) == 0);
            Val1 = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom);
            Val2 = ($urandom_range(0, 1) == 0) ? Val1 : W'($urandom);
            #1;
            checks++; if (ID_PC !== m_pc) begin errors++; $display("FAIL rnd_id_pc[%0d]: got %h expected %h", n, ID_PC, m_pc); end
            checks++; if (ID_Instruction !== m_ins) begin errors++; $display("FAIL rnd_id_instr[%0d]: got %h expected %h", n, ID_Instruction, m_ins); end
            checks++; if (ID_valid !== m_valid) begin errors++; $display("FAIL rnd_id_valid[%0d]: got %b expected %b", n, ID_valid, m_valid); end
            checks++; if (Br_taken !== m_taken()) begin errors++; $display("FAIL rnd_br_taken[%0d]: got %b expected %b", n, Br_taken, m_taken()); end
            checks++; if (Br_Addr !== m_addr()) begin errors++; $display("FAIL rnd_br_addr[%0d]: got %h expected %h", n, Br_Addr, m_addr()); end
            tick();
        end
`ifdef BRANCH_STATS_EN
        checks++; if (br_count !== m_br) begin errors++; $display("FAIL rnd_br_count: got %0d expected %0d", br_count, m_br); end
        checks++; if (taken_count !== m_tk) begin errors++; $display("FAIL rnd_taken_count: got %0d expected %0d", taken_count, m_tk); end
`endif
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        freeze = 1'b0;
        rst = 1'b1; #1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step(W'(32'h100), mk(42, 16'd2), 1'b0, '0, '0);
        step(W'(32'h104), mk(7, 16'd0), 1'b0, '0, '0);
        step(W'(32'h300), mk(41, 16'd1), 1'b0, '0, '0);
        step(W'(32'h304), mk(7, 16'd0), 1'b0, W'(1), W'(2));
        step(W'(32'h400), mk(40, 16'd1), 1'b0, '0, '0);
        step(W'(32'h404), mk(7, 16'd0), 1'b0, '0, W'(3));
        step(W'(32'h500), mk(41, 16'd8), 1'b0, '0, '0);
        step(W'(32'h504), mk(1, 16'd9), 1'b0, W'(7), W'(7));
        step(W'(32'h508), mk(2, 16'd9), 1'b0, '0, '0);
        step(W'(32'h50C), 32'h0, 1'b0, '0, '0);
        checks++; if (br_count !== 32'd4) begin errors++; $display("FAIL stats_br_count: got %0d expected 4", br_count); end
        checks++; if (taken_count !== 32'd3) begin errors++; $display("FAIL stats_taken_count: got %0d expected 3", taken_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_jmp();
        test_bne();
        test_freeze();
        test_rst_mid_branch();
        test_random();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_branch_unit.md
# id_branch_unit

Decode-side partner of the fetch stage. It registers the fetched `PC`/`Instruction` pair (the IF/ID pipeline register) and decodes branch and jump instructions. It resolves branch conditions from register operands and drives the `Br_taken`/`Br_Addr` pair back to fetch. It also squashes the wrong-path instruction with a one-cycle bubble and honours a hazard freeze.

## Interface
Parameters:
- `WIDTH`, default 32: data and address width.

Ports:
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `PC`  input  WIDTH: fetch address of `Instruction`, from fetch.
- `Instruction`  input  32: fetched instruction word.
- `freeze`  input  1: hazard stall; hold the ID register.
- `Val1`  input  WIDTH: register-file value for the rs field of `ID_Instruction`.
- `Val2`  input  WIDTH: register-file value for the rt field of `ID_Instruction`.
- `Br_taken`  output  1: redirect fetch (combinational).
- `Br_Addr`  output  WIDTH: redirect target (combinational).
- `ID_PC`  output  WIDTH: registered PC.
- `ID_Instruction`  output  32: registered instruction.
- `ID_valid`  output  1: the ID register holds a real instruction, not a bubble.

## Operation
- Opcode field is [31:26]. Immediate field is [15:0], sign-extended to WIDTH.
- BEZ = 6'd40: taken when `Val1` == 0.
- BNE = 6'd41: taken when `Val1` != `Val2`.
- JMP = 6'd42: always taken.
- `Br_taken` = `ID_valid` & ~`freeze` & (branch opcode) & (condition).
- `Br_Addr` = `ID_PC` + 4 + (sext(imm) << 2), computed modulo 2^WIDTH with wrap-around and no overflow flag. It is driven whenever a branch opcode is present, and is 0 when no branch opcode is present.
- ID register update on each rising edge, in priority order:
  1. `rst` (asynchronous): `ID_PC`=0, `ID_Instruction`=0, `ID_valid`=0.
  2. `Br_taken`=1: load a bubble (`ID_Instruction`=0, `ID_valid`=0, `ID_PC`=0). The instruction on the inputs is wrong-path and is discarded.
  3. `freeze`=1: hold all ID register contents.
  4. Otherwise: load `PC`, `Instruction`, and `ID_valid`=1.
- Flush and freeze are never active together, because `Br_taken` is gated by ~`freeze`.
- A bubble never produces `Br_taken`. Two consecutive taken cycles are therefore impossible.
- Instruction word 0 is a NOP and is never decoded as a branch.

## Timing
- Reset values: `ID_PC`=0, `ID_Instruction`=0, `ID_valid`=0, `Br_taken`=0, `Br_Addr`=0. The first instruction appears at the ID register one edge after `rst` falls.
- The ID register has one cycle of latency from fetch.
- `Br_taken`/`Br_Addr` settle in the same cycle as the ID contents. Fetch samples them at the next edge, so the redirect penalty is one squashed instruction.
- When `freeze` falls, the held branch resolves in that same cycle, using the `Val1`/`Val2` presented in that cycle.
- If `rst` is asserted mid-branch, `Br_taken` drops immediately, combinationally, because `ID_valid` clears.

## Configuration
- `BRANCH_STATS_EN` defined:
  - Adds output `br_count` (32) and output `taken_count` (32). Both are cleared by `rst` and wrap at 2^32.
  - `br_count` increments on each edge where `ID_valid` & ~`freeze` & branch opcode are true.
  - `taken_count` increments on each edge where `Br_taken` is 1.
- `BRANCH_STATS_EN` undefined: neither port nor the counters exist, and the remaining behaviour is identical.

## Structure
- Shared package: opcode constants `OP_BEZ`, `OP_BNE`, `OP_JMP`, the NOP word, and the field bit-position constants.
- One sub-module, `branch_cond`. It is purely combinational: inputs are opcode, `Val1`, and `Val2`; outputs are `is_branch` and `cond_true`.
- The ID register, flush logic, target adder and counters stay in the top module.

## Test plan
- Reset then release with `PC`=0 and `Instruction`=0x00000000 → all outputs 0. After one edge, `ID_valid`=1 and `Br_taken`=0.
- JMP fetched at `PC`=0x10 with imm=3 → the next cycle shows `Br_taken`=1 and `Br_Addr`=0x20. The edge after that shows `ID_valid`=0 and `ID_Instruction`=0.
- BNE with `Val1`=5, `Val2`=5 → `Br_taken`=0. Then BNE with `Val1`=5, `Val2`=6 and imm=-2 at `ID_PC`=0x40 → `Br_Addr`=0x3C.
- BEZ with `Val1`=0 while `freeze`=1 for 3 cycles → `Br_taken`=0 and the ID register is held. When `freeze` drops → `Br_taken`=1 in that cycle.
- `rst` pulsed while a taken JMP is in ID → `Br_taken` falls without waiting for an edge, and all registers read 0.
- With `BRANCH_STATS_EN` defined: 4 branches, 3 of them taken, plus 2 non-branch instructions → `br_count`=4 and `taken_count`=3.
